pmem_arbiter: RTL and testbench

Arbitrates a single physical-memory port between the instruction cache and the data cache. Each cache's miss/eviction FSM sees a private pmem port with the same read/write/resp handshake the caches already use. The arbiter serializes cache-line transactions onto the shared memory bus with round-robin fairness. It sits between the two cache_control/datapath pairs and the cacheline adaptor/physical memory.

---
 rtl/pmem_arbiter.sv | 109 ++++++++++
 tb/tb_pmem_arbiter.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pmem_arbiter.sv
// pmem_arbiter: round-robin sharing of one physical-memory port between icache and dcache.
// Grant one cycle after a request is seen in IDLE; the owner keeps the bus until pmem_resp, then one IDLE cycle.
module pmem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  i_pmem_read,
  input  logic [ADDR_WIDTH-1:0] i_pmem_address,
  output logic [LINE_WIDTH-1:0] i_pmem_rdata,
  output logic                  i_pmem_resp,

  input  logic                  d_pmem_read,
  input  logic                  d_pmem_write,
  input  logic [ADDR_WIDTH-1:0] d_pmem_address,
  input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
  output logic [LINE_WIDTH-1:0] d_pmem_rdata,
  output logic                  d_pmem_resp,

  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_e;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  state_e state_q, state_d;
  logic   last_grant_q, last_grant_d;
  logic   i_req, d_req;

  assign i_req = i_pmem_read;
  assign d_req = d_pmem_read | d_pmem_write;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_D;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // On a tie the requester that did not win last time is granted.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (i_req && (!d_req || (last_grant_q == GRANT_D))) begin
          state_d      = SERVE_I;
          last_grant_d = GRANT_I;
        end else if (d_req) begin
          state_d      = SERVE_D;
          last_grant_d = GRANT_D;
        end
      end
      SERVE_I, SERVE_D: begin
        if (pmem_resp) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Memory-side mux follows the registered grant; reset forces the strobes low at once.
  always_comb begin
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    i_pmem_resp  = 1'b0;
    d_pmem_resp  = 1'b0;
    if (!rst) begin
      case (state_q)
        SERVE_I: begin
          pmem_read    = 1'b1;
          pmem_address = i_pmem_address;
          i_pmem_resp  = pmem_resp;
        end
        SERVE_D: begin
          pmem_read    = d_pmem_read & ~d_pmem_write;
          pmem_write   = d_pmem_write;
          pmem_address = d_pmem_address;
          pmem_wdata   = d_pmem_wdata;
          d_pmem_resp  = pmem_resp;
        end
        default: ;
      endcase
    end
  end

  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Scoreboard bench for pmem_arbiter: requester and memory models drive random traffic,
// a transaction-level reference predicts grants/responses, a monitor compares the DUT bus.
module tb_pmem_arbiter;
  localparam int AW = 32;
  localparam int LW = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_pmem_read;
  logic [AW-1:0] i_pmem_address;
  logic [LW-1:0] i_pmem_rdata;
  logic          i_pmem_resp;
  logic          d_pmem_read;
  logic          d_pmem_write;
  logic [AW-1:0] d_pmem_address;
  logic [LW-1:0] d_pmem_wdata;
  logic [LW-1:0] d_pmem_rdata;
  logic          d_pmem_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata;
  logic          pmem_resp;

  pmem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk(clk), .rst(rst),
    .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
    .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [AW-1:0] addr; logic [LW-1:0] wdata; logic rd; logic wr; int gap; int hold; } req_t;
  typedef struct { bit who; logic rd; logic wr; logic [AW-1:0] addr; logic [LW-1:0] wdata; int cyc; } grant_t;
  typedef struct { bit who; logic [LW-1:0] rdata; } resp_t;

  int checks = 0;
  int errors = 0;

  req_t   iq[$], dq[$];
  grant_t gq[$];
  resp_t  rq[$];
  bit     grant_log[$];

  // requester, memory and reference-model state
  bit i_busy, d_busy, i_got_resp, d_got_resp;
  int i_wait, d_wait, i_hold;
  bit mem_busy, mem_fixed, spurious_en, quiet;
  int mem_cnt, mem_lat;
  logic [LW-1:0] mem_fixed_val;
  bit ireq_s, dreq_s, strobe_s;
  bit m_busy, m_owner, m_last_d;
  int i_resp_cnt = 0, d_resp_cnt = 0;
  logic [LW-1:0] last_i_rdata;

  function automatic void check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endfunction

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic void push_i(input logic [AW-1:0] a, input int gap, input int hold);
    req_t r;
    r.addr = a; r.wdata = '0; r.rd = 1'b1; r.wr = 1'b0; r.gap = gap; r.hold = hold;
    iq.push_back(r);
  endfunction

  function automatic void push_d(input logic [AW-1:0] a, input logic [LW-1:0] w, input logic rd, input logic wr, input int gap);
    req_t r;
    r.addr = a; r.wdata = w; r.rd = rd; r.wr = wr; r.gap = gap; r.hold = 0;
    dq.push_back(r);
  endfunction

  task automatic drive_i(input logic r);
    req_t it;
    if (r) begin
      i_busy = 1'b0; i_pmem_read = 1'b0; i_wait = 0;
    end else if (i_busy) begin
      if (i_got_resp) begin
        i_busy = 1'b0; i_pmem_read = 1'b0;
      end else if (i_hold > 0) begin
        i_hold--;
        if (i_hold == 0) i_pmem_read = 1'b0;
      end
    end else if (iq.size() > 0) begin
      if (i_wait < iq[0].gap) i_wait++;
      else begin
        it = iq.pop_front();
        i_wait = 0; i_busy = 1'b1; i_hold = it.hold;
        i_pmem_read = 1'b1; i_pmem_address = it.addr;
      end
    end
  endtask

  task automatic drive_d(input logic r);
    req_t it;
    if (r) begin
      d_busy = 1'b0; d_pmem_read = 1'b0; d_pmem_write = 1'b0; d_wait = 0;
    end else if (d_busy) begin
      if (d_got_resp) begin
        d_busy = 1'b0; d_pmem_read = 1'b0; d_pmem_write = 1'b0;
      end
    end else if (dq.size() > 0) begin
      if (d_wait < dq[0].gap) d_wait++;
      else begin
        it = dq.pop_front();
        d_wait = 0; d_busy = 1'b1;
        d_pmem_read = it.rd; d_pmem_write = it.wr;
        d_pmem_address = it.addr; d_pmem_wdata = it.wdata;
      end
    end
  endtask

  // Transaction-level reference: the bus is owned by one requester from grant to memory response;
  // a free bus goes to the sole requester, or on contention to the one not granted last.
  task automatic model_update();
    grant_t g;
    resp_t  rr;
    bit     pick_d;
    if (rst) begin
      m_busy = 1'b0; m_last_d = 1'b1;
      gq.delete(); rq.delete();
    end else if (!m_busy) begin
      if (ireq_s || dreq_s) begin
        pick_d = (ireq_s && dreq_s) ? !m_last_d : dreq_s;
        g.who = pick_d; g.cyc = cyc;
        if (pick_d) begin
          g.wr = d_pmem_write; g.rd = !d_pmem_write;
          g.addr = d_pmem_address; g.wdata = d_pmem_wdata;
        end else begin
          g.wr = 1'b0; g.rd = 1'b1; g.addr = i_pmem_address; g.wdata = '0;
        end
        gq.push_back(g);
        m_busy = 1'b1; m_owner = pick_d; m_last_d = pick_d;
      end
    end else if (pmem_resp) begin
      rr.who = m_owner; rr.rdata = pmem_rdata;
      rq.push_back(rr);
      m_busy = 1'b0;
    end
  endtask

  // One clock: drive on the falling edge, sample 3 time units later (well before the rising edge).
  task automatic step(input logic r);
    @(negedge clk);
    rst = r;
    pmem_resp = 1'b0;
    if (!r && mem_busy) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        pmem_resp = 1'b1;
        pmem_rdata = mem_fixed ? mem_fixed_val : rand_line();
        mem_busy = 1'b0;
      end
    end else if (!r && spurious_en && quiet && ($urandom_range(0, 7) == 0)) begin
      pmem_resp = 1'b1;
      pmem_rdata = rand_line();
    end
    drive_i(r);
    drive_d(r);
    #3;
    i_got_resp = i_pmem_resp;
    d_got_resp = d_pmem_resp;
    ireq_s = i_pmem_read;
    dreq_s = d_pmem_read | d_pmem_write;
    strobe_s = pmem_read | pmem_write;
    if (rst) mem_busy = 1'b0;
    else if (!mem_busy && !pmem_resp && strobe_s) begin
      mem_busy = 1'b1;
      mem_cnt = (mem_lat > 0) ? mem_lat : $urandom_range(1, 4);
    end
    quiet = !rst && !strobe_s && !ireq_s && !dreq_s && !pmem_resp;
    model_update();
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((iq.size() > 0 || dq.size() > 0 || i_busy || d_busy || mem_busy) && n < budget) begin
      step(1'b0);
      n++;
    end
    check({name, "_timeout"}, n < budget, 1'b1);
    step(1'b0);
    step(1'b0);
  endtask

  // Monitor: pops the expected grant when a new bus transaction starts and the expected
  // response whenever one is due, and checks idle-bus zeros the rest of the time.
  initial begin
    grant_t cur;
    resp_t  er;
    bit     in_txn = 1'b0;
    bit     prev_rst = 1'b0;
    logic   strobe;
    forever begin
      @(negedge clk);
      #4;
      strobe = pmem_read | pmem_write;
      if (rst) begin
        if (prev_rst) check("reset_outputs", {pmem_read, pmem_write, i_pmem_resp, d_pmem_resp, pmem_address, pmem_wdata}, '0);
        in_txn = 1'b0;
        prev_rst = 1'b1;
        continue;
      end
      if (prev_rst) check("post_reset_outputs", {pmem_read, pmem_write, i_pmem_resp, d_pmem_resp, pmem_address, pmem_wdata}, '0);
      prev_rst = 1'b0;
      if (i_pmem_resp) begin i_resp_cnt++; last_i_rdata = i_pmem_rdata; end
      if (d_pmem_resp) d_resp_cnt++;
      if (strobe && !in_txn) begin
        check("grant_expected", gq.size() > 0, 1'b1);
        if (gq.size() > 0) begin
          cur = gq.pop_front();
          in_txn = 1'b1;
          grant_log.push_back(cur.who);
          check("grant_latency", cyc, cur.cyc + 1);
        end
      end
      if (in_txn) begin
        check("bus_read", pmem_read, cur.rd);
        check("bus_write", pmem_write, cur.wr);
        check("bus_address", pmem_address, cur.addr);
        check("bus_wdata", pmem_wdata, cur.wdata);
      end else begin
        check("idle_bus", {pmem_read, pmem_write, pmem_address, pmem_wdata}, '0);
      end
      if (rq.size() > 0) begin
        er = rq.pop_front();
        check("i_resp", i_pmem_resp, er.who == 1'b0);
        check("d_resp", d_pmem_resp, er.who == 1'b1);
        check("i_rdata", i_pmem_rdata, er.rdata);
        check("d_rdata", d_pmem_rdata, er.rdata);
        in_txn = 1'b0;
      end else begin
        check("no_client_resp", {i_pmem_resp, d_pmem_resp}, 2'b00);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base, ic0, dc0;
    int n;
    logic [LW-1:0] pat;
    rst = 1'b1;
    i_pmem_read = 1'b0; i_pmem_address = '0;
    d_pmem_read = 1'b0; d_pmem_write = 1'b0; d_pmem_address = '0; d_pmem_wdata = '0;
    pmem_resp = 1'b0; pmem_rdata = '0;
    mem_lat = 0; mem_fixed = 1'b0; mem_fixed_val = '0; spurious_en = 1'b0; quiet = 1'b0;
    mem_busy = 1'b0; m_busy = 1'b0; m_last_d = 1'b1;
    i_busy = 1'b0; d_busy = 1'b0; i_wait = 0; d_wait = 0; i_hold = 0;

    step(1'b1); step(1'b1); step(1'b1);
    step(1'b0);

    // icache alone, 3-cycle memory, fixed data
    pat = {32{8'hAA}};
    mem_lat = 3; mem_fixed = 1'b1; mem_fixed_val = pat;
    ic0 = i_resp_cnt; dc0 = d_resp_cnt;
    push_i(32'h0000_1000, 0, 0);
    drain("ionly", 100);
    check("ionly_i_resp_count", i_resp_cnt - ic0, 1);
    check("ionly_d_resp_count", d_resp_cnt - dc0, 0);
    check("ionly_rdata", last_i_rdata, pat);

    // dcache writeback
    mem_lat = 2; mem_fixed = 1'b0;
    ic0 = i_resp_cnt; dc0 = d_resp_cnt;
    push_d(32'h0000_2040, {32{8'h55}}, 1'b0, 1'b1, 0);
    drain("wb", 100);
    check("wb_d_resp_count", d_resp_cnt - dc0, 1);
    check("wb_i_resp_count", i_resp_cnt - ic0, 0);

    // simultaneous requests straight out of reset: icache first
    step(1'b1); step(1'b1);
    mem_lat = 0;
    base = grant_log.size();
    push_i($urandom & 32'hFFFF_FFE0, 0, 0);
    push_d($urandom & 32'hFFFF_FFE0, rand_line(), 1'b1, 1'b0, 0);
    drain("tie", 200);
    check("tie_grants", grant_log.size() - base, 2);
    for (int k = 0; k < 2 && base + k < grant_log.size(); k++)
      check($sformatf("tie_order_%0d", k), grant_log[base + k], k % 2);

    // sustained contention: strict alternation
    base = grant_log.size();
    for (int k = 0; k < 3; k++) begin
      push_i($urandom & 32'hFFFF_FFE0, 0, 0);
      push_d($urandom & 32'hFFFF_FFE0, rand_line(), 1'b0, 1'b1, 0);
    end
    drain("contend", 400);
    check("contend_grants", grant_log.size() - base, 6);
    for (int k = 0; k < 6 && base + k < grant_log.size(); k++)
      check($sformatf("contend_order_%0d", k), grant_log[base + k], k % 2);

    // icache drops its request after one serve cycle; next tie goes to the dcache
    mem_lat = 4;
    ic0 = i_resp_cnt;
    push_i($urandom & 32'hFFFF_FFE0, 0, 2);
    drain("drop", 100);
    check("drop_i_resp_count", i_resp_cnt - ic0, 1);
    mem_lat = 0;
    base = grant_log.size();
    push_i($urandom & 32'hFFFF_FFE0, 0, 0);
    push_d($urandom & 32'hFFFF_FFE0, rand_line(), 1'b1, 1'b0, 0);
    drain("drop_tie", 200);
    check("drop_tie_grants", grant_log.size() - base, 2);
    for (int k = 0; k < 2 && base + k < grant_log.size(); k++)
      check($sformatf("drop_tie_order_%0d", k), grant_log[base + k], (k + 1) % 2);

    // reset while the dcache owns the bus
    mem_lat = 6;
    dc0 = d_resp_cnt;
    push_d(32'h0000_3000, rand_line(), 1'b0, 1'b1, 0);
    n = 0;
    while (!pmem_write && n < 20) begin step(1'b0); n++; end
    check("rst_mid_write_seen", pmem_write, 1'b1);
    step(1'b0);
    step(1'b1);
    step(1'b0);
    check("rst_mid_strobes", {pmem_read, pmem_write}, 2'b00);
    check("rst_mid_no_d_resp", d_resp_cnt - dc0, 0);
    mem_lat = 0;
    base = grant_log.size();
    push_i($urandom & 32'hFFFF_FFE0, 0, 0);
    push_d($urandom & 32'hFFFF_FFE0, rand_line(), 1'b1, 1'b1, 0);
    drain("rst_tie", 200);
    check("rst_tie_grants", grant_log.size() - base, 2);
    for (int k = 0; k < 2 && base + k < grant_log.size(); k++)
      check($sformatf("rst_tie_order_%0d", k), grant_log[base + k], k % 2);

    // random traffic with random memory latency and stray responses on an idle bus
    spurious_en = 1'b1;
    for (int k = 0; k < 40; k++) begin
      int t;
      push_i($urandom & 32'hFFFF_FFE0, $urandom_range(0, 3), 0);
      t = $urandom_range(0, 2);
      push_d($urandom & 32'hFFFF_FFE0, rand_line(), t != 1, t != 0, $urandom_range(0, 3));
    end
    drain("random", 5000);
    spurious_en = 1'b0;
    step(1'b0);
    check("final_grants_left", gq.size(), 0);
    check("final_resps_left", rq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
